// File: rtl/ser_rx_if.sv
// Output word handshake between the serial receiver and its consumer.
interface ser_rx_if #(
   parameter int unsigned SIZE = 8
);
   logic [SIZE-1:0] DataOut;
   logic            Valid;
   logic            Ready;

   modport master (output DataOut, output Valid, input Ready);
   modport slave  (input DataOut, input Valid, output Ready);
endinterface

// File: rtl/ser_rx.sv
// MSB-first serial-to-parallel receiver with a one-word holding register,
// sticky overrun (dropped word) and frame error (restart mid-word) flags.
module ser_rx #(
   parameter int unsigned SIZE = 8
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic                     Clr,
   input  logic                     BitEn,
   input  logic                     SerIn,
   input  logic                     Sof,
   ser_rx_if.master                 bus,
   output logic [$clog2(SIZE)-1:0]  BitCnt,
   output logic                     Overrun,
   output logic                     FrameErr
);

   localparam int unsigned CW = $clog2(SIZE);
   localparam int unsigned SW = SIZE - 1;

   logic [SW-1:0]   sh_q, sh_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [SIZE-1:0] data_q, data_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;
   logic            ferr_q, ferr_d;

   logic [CW-1:0]   eff_cnt;
   logic [SIZE-1:0] word;
   logic            complete;

   // A Sof cycle restarts the count so the current bit becomes the MSB.
   always_comb begin
      sh_d     = sh_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      valid_d  = valid_q;
      ovr_d    = ovr_q;
      ferr_d   = ferr_q;
      eff_cnt  = Sof ? '0 : cnt_q;
      word     = {sh_q, SerIn};
      complete = BitEn && (eff_cnt == CW'(SIZE - 1));

      if (Clr) begin
         sh_d    = '0;
         cnt_d   = '0;
         data_d  = '0;
         valid_d = 1'b0;
         ovr_d   = 1'b0;
         ferr_d  = 1'b0;
      end else begin
         if (Sof && (cnt_q != '0)) begin
            ferr_d = 1'b1;
         end

         if (BitEn) begin
            sh_d  = SW'({sh_q, SerIn});
            cnt_d = complete ? '0 : eff_cnt + CW'(1);
         end else if (Sof) begin
            cnt_d = '0;
         end

         // A completed word is accepted if the holding register is free or draining now.
         if (complete) begin
            if (!valid_q || bus.Ready) begin
               data_d  = word;
               valid_d = 1'b1;
            end else begin
               ovr_d = 1'b1;
            end
         end else if (valid_q && bus.Ready) begin
            valid_d = 1'b0;
         end
      end
   end

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         data_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         ferr_q  <= ferr_d;
      end
   end

   assign bus.DataOut = data_q;
   assign bus.Valid   = valid_q;
   assign BitCnt      = cnt_q;
   assign Overrun     = ovr_q;
   assign FrameErr    = ferr_q;

endmodule

// File: tb/tb_ser_rx.sv
// Bench for ser_rx: queue-based word model checked every cycle, directed
// scenarios with literal expectations, then randomized traffic.
module tb_ser_rx;

   localparam int unsigned SIZE = 8;
   localparam int unsigned CW   = $clog2(SIZE);

   logic          Clk   = 1'b0;
   logic          Rst_n = 1'b0;
   logic          Clr   = 1'b0;
   logic          BitEn = 1'b0;
   logic          SerIn = 1'b0;
   logic          Sof   = 1'b0;
   logic [CW-1:0] BitCnt;
   logic          Overrun;
   logic          FrameErr;

   ser_rx_if #(.SIZE(SIZE)) bus ();

   ser_rx #(.SIZE(SIZE)) dut (
      .Clk      (Clk),
      .Rst_n    (Rst_n),
      .Clr      (Clr),
      .BitEn    (BitEn),
      .SerIn    (SerIn),
      .Sof      (Sof),
      .bus      (bus),
      .BitCnt   (BitCnt),
      .Overrun  (Overrun),
      .FrameErr (FrameErr)
   );

   always #5 Clk = ~Clk;

   // Model: the bits of the word in progress, plus the visible outputs.
   bit              mq[$];
   logic [SIZE-1:0] m_data  = '0;
   bit              m_valid = 1'b0;
   bit              m_ovr   = 1'b0;
   bit              m_ferr  = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      mq.delete();
      m_data  = '0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      m_ferr  = 1'b0;
   endtask

   task automatic model_step(input bit clr, input bit ben, input bit ser, input bit sof, input bit rdy);
      logic [SIZE-1:0] w;
      bit              done;
      done = 1'b0;
      w    = '0;
      if (clr) begin
         model_reset();
         return;
      end
      if (sof && mq.size() != 0) m_ferr = 1'b1;
      if (sof) mq.delete();
      if (ben) begin
         mq.push_back(ser);
         if (mq.size() == SIZE) begin
            for (int i = 0; i < SIZE; i++) if (mq[i]) w = w + (SIZE'(1) << (SIZE - 1 - i));
            mq.delete();
            done = 1'b1;
         end
      end
      if (done) begin
         if (!m_valid || rdy) begin
            m_data  = w;
            m_valid = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_valid && rdy) begin
         m_valid = 1'b0;
      end
   endtask

   // Every cycle: registered outputs must match the model.
   always @(negedge Clk) begin
      chk("DataOut", 32'(bus.DataOut), 32'(m_data));
      chk("Valid", 32'(bus.Valid), 32'(m_valid));
      chk("BitCnt", 32'(BitCnt), 32'(mq.size()));
      chk("Overrun", 32'(Overrun), 32'(m_ovr));
      chk("FrameErr", 32'(FrameErr), 32'(m_ferr));
   end

   task automatic cycle(input bit clr, input bit ben, input bit ser, input bit sof, input bit rdy);
      Clr       = clr;
      BitEn     = ben;
      SerIn     = ser;
      Sof       = sof;
      bus.Ready = rdy;
      @(posedge Clk);
      if (!Rst_n) model_reset();
      else model_step(clr, ben, ser, sof, rdy);
      @(negedge Clk);
   endtask

   task automatic send_word(input logic [SIZE-1:0] w, input bit sof, input bit rdy_mid,
                            input bit rdy_last, input bit gap);
      for (int i = SIZE - 1; i >= 0; i--) begin
         cycle(1'b0, 1'b1, w[i], sof && (i == SIZE - 1), (i == 0) ? rdy_last : rdy_mid);
         if (gap && i > 0) cycle(1'b0, 1'b0, 1'($urandom), 1'b0, rdy_mid);
      end
   endtask

   logic [SIZE-1:0] w81 = 8'h81;

   initial begin
      bus.Ready = 1'b0;
      cycle(0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0);
      chk("rst_valid", 32'(bus.Valid), 32'h0);
      chk("rst_data", 32'(bus.DataOut), 32'h0);
      Rst_n = 1'b1;
      cycle(0, 0, 0, 0, 0);

      // Single word, Ready low
      send_word(8'hA5, 1, 0, 0, 0);
      chk("single_valid", 32'(bus.Valid), 32'h1);
      chk("single_data", 32'(bus.DataOut), 32'hA5);
      chk("single_cnt", 32'(BitCnt), 32'h0);
      chk("single_flags", 32'({Overrun, FrameErr}), 32'h0);

      // Streaming with Ready high
      cycle(1, 0, 0, 0, 0);
      send_word(8'h3C, 1, 1, 1, 0);
      chk("stream_data0", 32'(bus.DataOut), 32'h3C);
      chk("stream_valid0", 32'(bus.Valid), 32'h1);
      send_word(8'hFF, 0, 1, 1, 0);
      chk("stream_data1", 32'(bus.DataOut), 32'hFF);
      chk("stream_valid1", 32'(bus.Valid), 32'h1);
      cycle(0, 0, 0, 0, 1);
      chk("stream_drain", 32'(bus.Valid), 32'h0);
      chk("stream_flags", 32'({Overrun, FrameErr}), 32'h0);

      // Overrun
      cycle(1, 0, 0, 0, 0);
      send_word(8'h11, 1, 0, 0, 0);
      send_word(8'h22, 1, 0, 0, 0);
      chk("ovr_data", 32'(bus.DataOut), 32'h11);
      chk("ovr_flag", 32'(Overrun), 32'h1);
      cycle(0, 0, 0, 0, 1);
      chk("ovr_drain", 32'(bus.Valid), 32'h0);
      chk("ovr_sticky", 32'(Overrun), 32'h1);
      cycle(1, 0, 0, 0, 0);
      chk("ovr_clr", 32'(Overrun), 32'h0);

      // Accept and complete on the same edge
      send_word(8'h11, 1, 0, 0, 0);
      send_word(8'h22, 1, 0, 1, 0);
      chk("b2b_valid", 32'(bus.Valid), 32'h1);
      chk("b2b_data", 32'(bus.DataOut), 32'h22);
      chk("b2b_ovr", 32'(Overrun), 32'h0);

      // Frame restart after 3 bits
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, w81[SIZE-1], 1, 0);
      chk("fe_flag", 32'(FrameErr), 32'h1);
      chk("fe_cnt", 32'(BitCnt), 32'h1);
      for (int i = SIZE - 2; i >= 0; i--) cycle(0, 1, w81[i], 0, 0);
      chk("fe_data", 32'(bus.DataOut), 32'h81);
      chk("fe_valid", 32'(bus.Valid), 32'h1);

      // Clear mid-word with both flags set, then gapped word
      send_word(8'h5A, 0, 0, 0, 0);
      chk("clr_pre_ovr", 32'(Overrun), 32'h1);
      cycle(0, 1, 1, 0, 0);
      cycle(0, 1, 0, 0, 0);
      cycle(1, 1, 1, 1, 1);
      chk("clr_all", 32'({bus.DataOut, bus.Valid, BitCnt, Overrun, FrameErr}), 32'h0);
      send_word(8'hC3, 1, 0, 0, 1);
      chk("gap_data", 32'(bus.DataOut), 32'hC3);

      // Async reset mid-word; next word starts at its MSB without Sof
      cycle(1, 0, 0, 0, 0);
      cycle(0, 1, 1, 1, 0);
      cycle(0, 1, 1, 0, 0);
      #2 Rst_n = 1'b0;
      model_reset();
      cycle(0, 1, 1, 0, 0);
      chk("arst_cnt", 32'(BitCnt), 32'h0);
      Rst_n = 1'b1;
      send_word(8'h96, 0, 0, 0, 0);
      chk("arst_data", 32'(bus.DataOut), 32'h96);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
               ($urandom_range(0, 15) == 0), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/ser_rx.md
# ser_rx

Serial-to-parallel receiver forming the receive end of the team's MSB-first serial link. It pairs with the parallel-load shift-register transmitter: the transmitter's serial output drives SerIn and its shift enable drives BitEn. The block accumulates SIZE bits into a word and presents each word on DataOut with a Valid/Ready handshake. It flags a word lost to an unconsumed holding register, and a frame restarted mid-word.

## Interface
- SIZE, 8, word width in bits; legal range SIZE >= 2.
- Clk  in  1  clock, all state updates on rising edge.
- Rst_n  in  1  reset, asynchronous, active-low.
- Clr  in  1  synchronous clear of all state; highest priority below reset.
- BitEn  in  1  SerIn carries a valid bit this cycle.
- SerIn  in  1  serial data, MSB of each word first.
- Sof  in  1  start of frame; qualifies the current cycle as a word boundary.
- Ready  in  1  consumer accepts DataOut when Valid is high.
- DataOut  out  SIZE  last completed word, registered.
- Valid  out  1  DataOut holds an unconsumed word.
- BitCnt  out  $clog2(SIZE)  bits of the current word received so far.
- Overrun  out  1  sticky: a completed word was dropped.
- FrameErr  out  1  sticky: Sof arrived with a partial word pending.

## Operation
- Internal shift register `sh` (SIZE-1 bits used) and counter `cnt` (= BitCnt).
- Reset values: DataOut = 0, Valid = 0, BitCnt = 0, Overrun = 0, FrameErr = 0, `sh` = 0.
- Clr: same values as reset, applied on the clock edge; overrides BitEn, Sof and Ready.
- Bit capture (BitEn = 1): `sh` <= {sh, SerIn}; cnt increments.
- Word completion is BitEn = 1 with effective count SIZE-1. The assembled word {sh[SIZE-2:0], SerIn} is the completed word, and cnt <= 0.
- Sof rules:
  - Sof = 1 with BitEn = 1: the current bit is bit 0 (MSB) of a new word. Effective count is 0, so cnt <= 1 and any partial bits are discarded.
  - Sof = 1 with BitEn = 0: cnt <= 0.
  - Sof with cnt != 0 before the edge sets FrameErr.
  - Sof with cnt == 0 is legal and sets no flag.
- Handshake:
  - Valid clears on an edge where Valid & Ready, unless a word completes on the same edge.
  - Completion when Valid = 0, or when Valid & Ready: DataOut <= new word, Valid <= 1. This is a back-to-back accept with no flag.
  - Completion when Valid = 1 and Ready = 0: the new word is dropped, DataOut and Valid hold, Overrun <= 1.
  - DataOut changes only on an accepted completion, on Clr, or on reset.
- Overrun and FrameErr clear only on Clr or reset.
- SerIn is ignored when BitEn = 0. Ready is ignored when Valid = 0.

## Timing
- One bit per cycle maximum. BitEn may be held high continuously.
- Valid and DataOut update on the edge that samples the last bit, so they are visible the cycle after the last BitEn cycle.
- Minimum word period is SIZE cycles. Sustained throughput is one word per SIZE cycles when Ready is held high.
- Loopback timing: the transmitter is loaded on edge N with its enable high from edge N+1. The receiver, with Sof at edge N+1, delivers Valid from edge N+SIZE.
- Ready is sampled combinationally at the edge. No combinational path runs from any input to any output.
- An asynchronous reset assertion mid-word discards the partial word. After release, the first BitEn bit is treated as the MSB.

## Test plan
- **Reset and single word.** Stimulus: reset, then Sof + BitEn for 8 cycles with bits 1,0,1,0,0,1,0,1, Ready = 0. Required: Valid = 1, DataOut = 0xA5, BitCnt = 0, both flags 0.
- **Streaming.** Stimulus: words 0x3C then 0xFF sent back to back with BitEn always high and Ready always high. Required: Valid pulses one cycle each, with DataOut = 0x3C then 0xFF, eight cycles apart. No flags.
- **Overrun.** Stimulus: 0x11 is received with Ready = 0, then 0x22 completes. Required: DataOut stays 0x11 and Overrun = 1. Then Ready = 1 for one cycle gives Valid = 0; Overrun stays 1 until Clr.
- **Simultaneous accept and complete.** Stimulus: Valid high with 0x11, Ready = 1 on the same edge that 0x22 completes. Required: Valid stays 1, DataOut = 0x22, Overrun = 0.
- **Frame restart.** Stimulus: 3 bits received, then Sof + BitEn starts 0x81. Required: FrameErr = 1, BitCnt = 1 after the Sof edge, and 0x81 is delivered intact 7 bits later.
- **Clear and gated bits.** Stimulus: Clr mid-word with flags set, then 0xC3 sent with BitEn toggling 1,0 and SerIn randomised in the gaps. Required: all outputs 0 after Clr, and DataOut = 0xC3.
